// File: rtl/nibble_add_driver.sv
// nibble_add_driver: LFSR operand burst source and checker for a registered 4-bit nibble adder.
// Latency: operand launched at edge k is compared against sum_in at edge k+1+LATENCY; all outputs registered.
// Backpressure: none; operands issue back-to-back once started, and start is ignored unless IDLE.
// Optional: define NIBBLE_ADD_DRIVER_FIRST_ERR_EN to add first_err_idx / first_err_op outputs.
module nibble_add_driver #(
  parameter int COUNT_W = 8,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] n_pairs,
  input  logic [7:0]         seed,
  output logic [7:0]         op_out,
  output logic               op_valid,
  input  logic [3:0]         sum_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [COUNT_W-1:0] err_count
`ifdef NIBBLE_ADD_DRIVER_FIRST_ERR_EN
  ,
  output logic [COUNT_W-1:0] first_err_idx,
  output logic [7:0]         first_err_op
`endif
);

  localparam int DEPTH = LATENCY + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [7:0]         lfsr;
  logic [COUNT_W-1:0] remaining;

  // Expected-result delay line; stage LATENCY lines up with sum_in.
  logic [DEPTH-1:0]   vld_pipe;
  logic [3:0]         exp_pipe [DEPTH];

`ifdef NIBBLE_ADD_DRIVER_FIRST_ERR_EN
  logic [COUNT_W-1:0] launch_idx;
  logic [COUNT_W-1:0] idx_pipe [DEPTH];
  logic [7:0]         op_pipe  [DEPTH];
`endif

  logic               start_ok;
  logic               launch;
  logic               last_launch;
  logic               drain_empty;
  logic               mismatch;
  logic               err_sat;

  logic [7:0]         op_out_nxt;
  logic               op_valid_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               pass_nxt;
  logic [COUNT_W-1:0] err_count_nxt;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  // Control decodes shared by next-state and output logic.
  always_comb begin
    start_ok    = (state == IDLE) && start;
    launch      = (state == RUN);
    last_launch = launch && (remaining == COUNT_W'(1));
    // Last operand sits in the tail once every earlier stage is empty.
    drain_empty = ~|vld_pipe[LATENCY-1:0];
    mismatch    = vld_pipe[LATENCY] && (sum_in != exp_pipe[LATENCY]);
    err_sat     = (err_count == {COUNT_W{1'b1}});
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (n_pairs == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_launch) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_empty) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    op_out_nxt    = launch ? lfsr : 8'h00;
    op_valid_nxt  = launch;
    busy_nxt      = (state_nxt == RUN) || (state_nxt == DRAIN);
    done_nxt      = (state == DONE);
    pass_nxt      = pass;
    err_count_nxt = err_count;
    if (start_ok) begin
      pass_nxt      = 1'b0;
      err_count_nxt = '0;
    end else begin
      if (state == DONE) pass_nxt = (err_count == '0);
      if (mismatch && !err_sat) err_count_nxt = err_count + COUNT_W'(1);
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_out    <= 8'h00;
      op_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      op_out    <= op_out_nxt;
      op_valid  <= op_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_count_nxt;
    end
  end

  // Operand generator: LFSR and remaining-pair counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr      <= 8'h01;
      remaining <= '0;
    end else if (start_ok) begin
      // All-zero is the LFSR lock-up state, so substitute 1.
      lfsr      <= (seed == 8'h00) ? 8'h01 : seed;
      remaining <= n_pairs;
    end else if (launch) begin
      lfsr      <= lfsr_step(lfsr);
      remaining <= remaining - COUNT_W'(1);
    end
  end

  // Expected-sum delay line, shifting every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < DEPTH; i++) exp_pipe[i] <= 4'h0;
    end else begin
      vld_pipe    <= {vld_pipe[LATENCY-1:0], launch};
      exp_pipe[0] <= lfsr[7:4] + lfsr[3:0];
      for (int i = 1; i < DEPTH; i++) exp_pipe[i] <= exp_pipe[i-1];
    end
  end

`ifdef NIBBLE_ADD_DRIVER_FIRST_ERR_EN
  // Operand byte and pair index travel alongside the expected sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      launch_idx <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_pipe[i] <= '0;
        op_pipe[i]  <= 8'h00;
      end
    end else begin
      if (start_ok)    launch_idx <= '0;
      else if (launch) launch_idx <= launch_idx + COUNT_W'(1);
      idx_pipe[0] <= launch_idx;
      op_pipe[0]  <= lfsr;
      for (int i = 1; i < DEPTH; i++) begin
        idx_pipe[i] <= idx_pipe[i-1];
        op_pipe[i]  <= op_pipe[i-1];
      end
    end
  end

  // First mismatch of a burst is the one seen while err_count is still zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_err_idx <= '0;
      first_err_op  <= 8'h00;
    end else if (start_ok) begin
      first_err_idx <= '0;
      first_err_op  <= 8'h00;
    end else if (mismatch && (err_count == '0)) begin
      first_err_idx <= idx_pipe[LATENCY];
      first_err_op  <= op_pipe[LATENCY];
    end
  end
`endif

endmodule

// File: tb/tb_nibble_add_driver.sv
module tb_nibble_add_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start3;
  logic [7:0] n_pairs, n3;
  logic [7:0] seed, seed3;
  logic [7:0] op_out, op_out3;
  logic       op_valid, op_valid3;
  logic [3:0] sum_in, sum_in3;
  logic       busy, done, pass, busy3, done3, pass3;
  logic [7:0] err_count, err_count3;
`ifdef NIBBLE_ADD_DRIVER_FIRST_ERR_EN
  logic [7:0] first_err_idx, first_err_op, first_err_idx3, first_err_op3;
`endif

  int total = 0;
  int bad   = 0;

  logic inject = 1'b0;
  logic slow   = 1'b1;
  logic [3:0] a1_q;
  logic [3:0] a3_s1, a3_s2, a3_s3;

  always #5 clk = ~clk;

  function automatic logic [3:0] nib_sum(input logic [7:0] b);
    return b[7:4] + b[3:0];
  endfunction

  // One-stage adder model; optional bit0 corruption on operand B8.
  always @(posedge clk) a1_q <= nib_sum(op_out) ^ {3'b000, (inject && op_valid && op_out == 8'hB8)};
  assign sum_in = a1_q;

  // Three-stage adder model, or its first stage only when slow is low.
  always @(posedge clk) begin
    a3_s1 <= nib_sum(op_out3);
    a3_s2 <= a3_s1;
    a3_s3 <= a3_s2;
  end
  assign sum_in3 = slow ? a3_s3 : a3_s1;

  nibble_add_driver #(.COUNT_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .n_pairs(n_pairs), .seed(seed),
    .op_out(op_out), .op_valid(op_valid), .sum_in(sum_in), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count)
`ifdef NIBBLE_ADD_DRIVER_FIRST_ERR_EN
    , .first_err_idx(first_err_idx), .first_err_op(first_err_op)
`endif
  );

  nibble_add_driver #(.COUNT_W(8), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .n_pairs(n3), .seed(seed3),
    .op_out(op_out3), .op_valid(op_valid3), .sum_in(sum_in3), .busy(busy3),
    .done(done3), .pass(pass3), .err_count(err_count3)
`ifdef NIBBLE_ADD_DRIVER_FIRST_ERR_EN
    , .first_err_idx(first_err_idx3), .first_err_op(first_err_op3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1);
  endtask

  logic [7:0] ops1 [4];
  int done_cnt, done_edge, vld_cnt;
  logic seen3;

  initial begin
    ops1 = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
    reset = 1'b1; start = 1'b0; n_pairs = 8'd0; seed = 8'd0;
    start3 = 1'b0; n3 = 8'd0; seed3 = 8'd0;
    #12;
    check("rst_op_out", op_out, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    @(negedge clk) reset = 1'b0;
    tick();

    // 1: ideal adder, seed 01, four pairs
    seed = 8'h01; n_pairs = 8'd4; start = 1'b1;
    tick(); start = 1'b0;
    check("t1_e0_busy", busy, 1);
    check("t1_e0_valid", op_valid, 0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("t1_op_out", op_out, ops1[e-1]);
      check("t1_op_valid", op_valid, 1);
    end
    tick();
    check("t1_e5_valid", op_valid, 0);
    check("t1_e5_op_out", op_out, 0);
    check("t1_e5_busy", busy, 1);
    tick();
    check("t1_e6_done", done, 0);
    tick();
    check("t1_e7_done", done, 1);
    check("t1_e7_pass", pass, 1);
    check("t1_e7_err", err_count, 0);
    tick();
    check("t1_e8_done", done, 0);
    check("t1_e8_busy", busy, 0);
    check("t1_e8_pass_held", pass, 1);

    // 2: corrupt the second result only
    inject = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check("t2_pass_cleared", pass, 0);
    wait_done("t2_done_seen", 20);
    check("t2_err", err_count, 1);
    check("t2_pass", pass, 0);
`ifdef NIBBLE_ADD_DRIVER_FIRST_ERR_EN
    check("t2_first_idx", first_err_idx, 1);
    check("t2_first_op", first_err_op, 8'hB8);
`endif
    inject = 1'b0;
    tick();

    // 3: zero pairs
    seed = 8'h5A; n_pairs = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    check("t3_e0_err_cleared", err_count, 0);
    check("t3_e0_busy", busy, 0);
    check("t3_e0_done", done, 0);
    check("t3_e0_valid", op_valid, 0);
    tick();
    check("t3_e1_done", done, 1);
    check("t3_e1_pass", pass, 1);
    check("t3_e1_err", err_count, 0);
    check("t3_e1_valid", op_valid, 0);
    tick();
    check("t3_e2_done", done, 0);

    // 4: zero seed, restart attempt while busy
    seed = 8'h00; n_pairs = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    check("t4_pass_cleared", pass, 0);
    tick();
    check("t4_op0", op_out, 8'h01);
    start = 1'b1;
    tick(); start = 1'b0;
    check("t4_op1", op_out, 8'hB8);
    done_cnt = 0; done_edge = -1;
    for (int e = 3; e <= 10; e++) begin
      tick();
      if (e == 3) check("t4_e3_valid", op_valid, 0);
      if (done) begin
        done_cnt++;
        done_edge = e;
      end
    end
    check("t4_done_cnt", done_cnt, 1);
    check("t4_done_edge", done_edge, 5);
    check("t4_pass", pass, 1);

    // 5: asynchronous reset mid-burst
    seed = 8'h01; n_pairs = 8'd10; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    check("t5_running", op_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_op_out", op_out, 0);
    check("t5_rst_valid", op_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_err", err_count, 0);
    tick(); tick();
    @(negedge clk) reset = 1'b0;
    done_cnt = 0; vld_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_cnt++;
      if (op_valid) vld_cnt++;
    end
    check("t5_no_done", done_cnt, 0);
    check("t5_no_valid", vld_cnt, 0);
    seed = 8'h33; n_pairs = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    wait_done("t5_done_seen", 20);
    check("t5_pass", pass, 1);
    check("t5_err", err_count, 0);

    // 6: LATENCY=3 against three-stage and one-stage adders
    seed3 = 8'h01; n3 = 8'd4; start3 = 1'b1;
    tick(); start3 = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 8) check("t6_e8_done", done3, 0);
      if (e == 9) begin
        check("t6_e9_done", done3, 1);
        check("t6_err", err_count3, 0);
        check("t6_pass", pass3, 1);
      end
    end
    slow = 1'b0;
    tick();
    start3 = 1'b1;
    tick(); start3 = 1'b0;
    seen3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done3) begin
        seen3 = 1'b1;
        break;
      end
    end
    check("t6_short_done_seen", seen3, 1);
    check("t6_short_err_nonzero", err_count3 != 8'd0, 1);
    check("t6_short_pass", pass3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_add_driver.md
Name: nibble_add_driver

Overview:
Stimulus-and-check driver for the registered 4-bit nibble adder, which takes a packed byte {a[3:0], b[3:0]} and returns (a+b) mod 16.
- On start, issues a burst of LFSR-generated operand bytes, one per cycle.
- Computes each expected sum internally and compares it against the returned sum after a fixed latency.
- Reports the error count and a pass flag.
- Sits on the operand side of the adder and serves as the built-in self-test and bring-up source.

Parameters:
COUNT_W, 8, width of n_pairs and err_count
LATENCY, 1, adder register stages between operand capture and sum output (min 1, max 4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin burst; sampled only in IDLE
n_pairs  in  COUNT_W  operand pairs to issue; captured on start
seed  in  8  LFSR seed; captured on start
op_out  out  8  operand byte, a=op_out[7:4], b=op_out[3:0]
op_valid  out  1  op_out carries a live operand this cycle
sum_in  in  4  sum returned by the adder
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle completion pulse
pass  out  1  last burst had zero mismatches; held until next start
err_count  out  COUNT_W  mismatches in the current or last burst

Behaviour:
- Reset: reset is asynchronous and active-high; clock is clk.
  - Reset values: op_out=0, op_valid=0, busy=0, done=0, pass=0, err_count=0.
  - State goes to IDLE, LFSR=8'h01, expected pipeline cleared.
- All outputs are registered.
- LFSR: 8-bit Galois, right shift.
  - next = lfsr[0] ? (lfsr>>1)^8'hB8 : lfsr>>1.
  - A seed of 8'h00 is replaced by 8'h01.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start, capture seed (zero-fixed) into the LFSR and n_pairs into the remaining counter.
  - Clear err_count and pass.
  - Go to RUN, or to DONE if n_pairs==0.
- RUN, each cycle:
  - op_out<=lfsr, op_valid<=1, lfsr advances, remaining decrements.
  - Push expected=(lfsr[7:4]+lfsr[3:0])[3:0] and a valid bit into a delay pipeline of depth LATENCY+1.
  - After the n_pairs-th launch, go to DRAIN; op_valid<=0 and op_out<=0 on that transition.
  - Operands are back-to-back with no gaps.
- Compare timing:
  - An operand launched at edge k has its sum_in sampled at edge k+1+LATENCY.
  - When the pipeline tail is valid and sum_in!=expected, err_count increments.
  - err_count saturates at all-ones.
- DRAIN: runs until the pipeline is empty (LATENCY+1 cycles after the last launch), then goes to DONE.
- DONE:
  - done=1 for exactly one cycle, with pass=(err_count==0) registered at the same edge; then return to IDLE.
  - With start sampled at edge 0 and n>0, the final compare happens at edge n+1+LATENCY and done goes high at edge n+2+LATENCY.
  - With n_pairs==0, done goes high at edge 1 with pass=1 and op_valid never asserted.
- start while busy or in DONE: ignored, with no restart or counter effect.
- Reset mid-burst: immediately returns all outputs to reset values; no done pulse; pipeline contents discarded.
- err_count and pass remain stable in IDLE until the next accepted start.

Optional Feature:
Macro NIBBLE_ADD_DRIVER_FIRST_ERR_EN.
- When defined, two extra output ports exist:
  - first_err_idx[COUNT_W-1:0]: zero-based pair index of the first mismatch.
  - first_err_op[7:0]: operand byte of the first mismatch.
- Both are captured at the first mismatch of a burst, cleared to 0 on reset and on accepted start, and frozen thereafter.
- The expected pipeline then also carries the operand byte and index (depth LATENCY+1).
- When not defined, these ports and the extra pipeline fields are absent; all other behaviour is identical.

Test Plan:
1. Ideal adder model (LATENCY=1), seed=8'h01, n_pairs=4, start at edge 0.
   - op_out = 01, B8, 5C, 2E on edges 1-4 with op_valid=1.
   - Expected sums 1, 3, 1, 0.
   - done pulse at edge 7, err_count=0, pass=1.
2. Same as 1 with sum_in bit0 inverted for the second result only.
   - err_count=1, pass=0.
   - With FIRST_ERR_EN: first_err_idx=1, first_err_op=8'hB8.
3. n_pairs=0, seed=8'h5A.
   - op_valid never high; done at edge 1; pass=1; err_count=0.
4. seed=8'h00, n_pairs=2.
   - op_out=01 then B8, same as seed 01.
   - Start pulsed again at edge 2 while busy: ignored, burst ends normally with a single done.
5. Reset asserted asynchronously during RUN of an n_pairs=10 burst.
   - All outputs go to 0 immediately, with no done.
   - A new start afterwards completes a clean burst with pass=1.
6. LATENCY=3 with an adder model delayed 3 stages, seed=8'h01, n_pairs=4.
   - done at edge 9, err_count=0.
   - With an adder model of only 1 stage, err_count is nonzero.
